// File: rtl/hwpe_stream_parity_fault_collector.sv
// Parity fault collector: merges parity-sink fault flags into sticky status,
// a saturating fault-cycle counter, first-fault capture, IRQ and escalation.
module hwpe_stream_parity_fault_collector #(
    parameter int unsigned NB_CHANNELS     = 4,
    parameter int unsigned CNT_WIDTH       = 16,
    parameter int unsigned FATAL_THRESHOLD = 16,
    localparam int unsigned ID_WIDTH =
        (NB_CHANNELS > 1) ? $clog2(NB_CHANNELS) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   clear_i,
    input  logic [NB_CHANNELS-1:0] fault_i,
    input  logic [NB_CHANNELS-1:0] mask_i,
    input  logic [NB_CHANNELS-1:0] ack_i,
    input  logic                   cnt_clear_i,
    output logic [NB_CHANNELS-1:0] status_o,
    output logic [CNT_WIDTH-1:0]   fault_cnt_o,
    output logic [ID_WIDTH-1:0]    first_id_o,
    output logic                   first_valid_o,
    output logic                   irq_o,
    output logic                   fatal_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALARM = 2'd1,
        FATAL = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [NB_CHANNELS-1:0] fault_q;
    logic [NB_CHANNELS-1:0] status_d;
    logic [CNT_WIDTH-1:0]   cnt_d;
    logic [ID_WIDTH-1:0]    low_id;
    logic                   any_fault;
    logic                   hit;

    assign any_fault = |fault_q;

    // Next sticky status and next counter value (clear beats increment).
    always_comb begin
        status_d = fault_q | (status_o & ~ack_i);
        cnt_d    = fault_cnt_o;
        if (cnt_clear_i) begin
            cnt_d = '0;
        end else if (any_fault && (fault_cnt_o != '1)) begin
            cnt_d = fault_cnt_o + 1'b1;
        end
    end

    // Escalation condition on the counter's next value.
    assign hit = (FATAL_THRESHOLD != 0) &&
                 ({1'b0, cnt_d} >= (CNT_WIDTH+1)'(FATAL_THRESHOLD));

    // Lowest-index faulting channel in the registered fault vector.
    always_comb begin
        low_id = '0;
        for (int i = NB_CHANNELS - 1; i >= 0; i--) begin
            if (fault_q[i]) begin
                low_id = ID_WIDTH'(i);
            end
        end
    end

    // Escalation next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (any_fault) begin
                    state_d = hit ? FATAL : ALARM;
                end
            end
            ALARM: begin
                if (hit) begin
                    state_d = FATAL;
                end else if (status_d == '0) begin
                    state_d = IDLE;
                end
            end
            FATAL:   state_d = FATAL;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else if (clear_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Input cut, sticky status, counter and first-fault capture.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fault_q       <= '0;
            status_o      <= '0;
            fault_cnt_o   <= '0;
            first_id_o    <= '0;
            first_valid_o <= 1'b0;
        end else if (clear_i) begin
            fault_q       <= '0;
            status_o      <= '0;
            fault_cnt_o   <= '0;
            first_id_o    <= '0;
            first_valid_o <= 1'b0;
        end else begin
            fault_q     <= fault_i;
            status_o    <= status_d;
            fault_cnt_o <= cnt_d;
            if (state_q == IDLE && any_fault) begin
                first_id_o    <= low_id;
                first_valid_o <= 1'b1;
            end else if (state_q != IDLE && state_d == IDLE) begin
                first_valid_o <= 1'b0;
            end
        end
    end

    assign irq_o   = |(status_o & mask_i);
    assign fatal_o = (state_q == FATAL);

endmodule

// File: tb/tb_hwpe_stream_parity_fault_collector.sv
// Bench for the parity fault collector: directed table, corner sequences
// and random traffic against a behavioural model.
module tb_hwpe_stream_parity_fault_collector;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic [3:0] fault = '0;
    logic [3:0] mask = '0;
    logic [3:0] ack = '0;
    logic       cclr = 1'b0;

    logic [3:0]  st_a, st_b;
    logic [15:0] cnt_a;
    logic [3:0]  cnt_b;
    logic [1:0]  fid_a, fid_b;
    logic        fv_a, fv_b, irq_a, irq_b, fat_a, fat_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    hwpe_stream_parity_fault_collector #(
        .NB_CHANNELS(4), .CNT_WIDTH(16), .FATAL_THRESHOLD(16)
    ) dut_a (
        .clk_i(clk), .rst_i(rst), .clear_i(clr), .fault_i(fault),
        .mask_i(mask), .ack_i(ack), .cnt_clear_i(cclr),
        .status_o(st_a), .fault_cnt_o(cnt_a), .first_id_o(fid_a),
        .first_valid_o(fv_a), .irq_o(irq_a), .fatal_o(fat_a)
    );

    hwpe_stream_parity_fault_collector #(
        .NB_CHANNELS(4), .CNT_WIDTH(4), .FATAL_THRESHOLD(0)
    ) dut_b (
        .clk_i(clk), .rst_i(rst), .clear_i(clr), .fault_i(fault),
        .mask_i(mask), .ack_i(ack), .cnt_clear_i(cclr),
        .status_o(st_b), .fault_cnt_o(cnt_b), .first_id_o(fid_b),
        .first_valid_o(fv_b), .irq_o(irq_b), .fatal_o(fat_b)
    );

    // Behavioural model: mode 0 = quiet, 1 = alarm, 2 = fatal.
    typedef struct packed {
        logic [3:0] fq;
        logic [3:0] st;
        int         cnt;
        int         fid;
        logic       fv;
        logic [1:0] mode;
    } m_t;

    m_t ma, mb;

    function automatic m_t step(m_t m, logic [3:0] f, logic [3:0] a,
                                logic cc, logic c, int maxc, int thr);
        m_t n;
        int cn;
        bit over;
        n = '0;
        if (c) return n;
        n = m;
        n.fq = f;
        n.st = m.fq | (m.st & ~a);
        if (cc) cn = 0;
        else if (m.fq != 0) cn = (m.cnt < maxc) ? m.cnt + 1 : maxc;
        else cn = m.cnt;
        n.cnt = cn;
        over = (thr != 0) && (cn >= thr);
        if (m.mode == 0 && m.fq != 0) n.mode = over ? 2'd2 : 2'd1;
        if (m.mode == 1) begin
            if (over) n.mode = 2'd2;
            else if (n.st == 0) n.mode = 2'd0;
        end
        if (m.mode == 0 && m.fq != 0) begin
            n.fv = 1'b1;
            for (int i = 3; i >= 0; i--) if (m.fq[i]) n.fid = i;
        end
        if (m.mode != 0 && n.mode == 0) n.fv = 1'b0;
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ma <= '0;
            mb <= '0;
        end else begin
            ma <= step(ma, fault, ack, cclr, clr, 65535, 16);
            mb <= step(mb, fault, ack, cclr, clr, 15, 0);
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic drive(logic [3:0] f, logic [3:0] m, logic [3:0] a,
                         logic cc, logic c);
        fault = f; mask = m; ack = a; cclr = cc; clr = c;
    endtask

    typedef struct {
        logic [3:0] f, m, a;
        logic       cc, c;
        logic [3:0] st;
        int         cnt;
        int         fid;
        logic       fv, irq, fat;
    } vec_t;

    vec_t vt[20];

    initial begin
        vt[0]  = '{4'b0100, 4'hF, 4'h0, 0, 0, 4'h0, 0, 0, 0, 0, 0};
        vt[1]  = '{4'b0000, 4'hF, 4'h0, 0, 0, 4'b0100, 1, 2, 1, 1, 0};
        vt[2]  = '{4'b0000, 4'hF, 4'b0100, 0, 0, 4'h0, 1, 2, 0, 0, 0};
        vt[3]  = '{4'b0001, 4'hF, 4'h0, 0, 0, 4'h0, 1, 2, 0, 0, 0};
        vt[4]  = '{4'b0001, 4'hF, 4'h0, 0, 0, 4'b0001, 2, 0, 1, 1, 0};
        vt[5]  = '{4'b0001, 4'hF, 4'b0001, 0, 0, 4'b0001, 3, 0, 1, 1, 0};
        vt[6]  = '{4'b0000, 4'hF, 4'b0001, 0, 0, 4'b0001, 4, 0, 1, 1, 0};
        vt[7]  = '{4'b0000, 4'hF, 4'b0001, 0, 0, 4'h0, 4, 0, 0, 0, 0};
        vt[8]  = '{4'b1010, 4'hF, 4'h0, 0, 0, 4'h0, 4, 0, 0, 0, 0};
        vt[9]  = '{4'b0001, 4'hF, 4'h0, 0, 0, 4'b1010, 5, 1, 1, 1, 0};
        vt[10] = '{4'b0000, 4'hF, 4'h0, 0, 0, 4'b1011, 6, 1, 1, 1, 0};
        vt[11] = '{4'b0000, 4'h0, 4'h0, 0, 0, 4'b1011, 6, 1, 1, 0, 0};
        vt[12] = '{4'b0000, 4'b0100, 4'h0, 0, 0, 4'b1011, 6, 1, 1, 0, 0};
        vt[13] = '{4'b0000, 4'b0010, 4'h0, 0, 0, 4'b1011, 6, 1, 1, 1, 0};
        vt[14] = '{4'b0000, 4'hF, 4'hF, 0, 0, 4'h0, 6, 1, 0, 0, 0};
        vt[15] = '{4'b0000, 4'hF, 4'h0, 1, 0, 4'h0, 0, 1, 0, 0, 0};
        vt[16] = '{4'b1111, 4'hF, 4'h0, 0, 0, 4'h0, 0, 1, 0, 0, 0};
        vt[17] = '{4'b0000, 4'hF, 4'h0, 0, 0, 4'hF, 1, 0, 1, 1, 0};
        vt[18] = '{4'b1111, 4'hF, 4'h0, 0, 1, 4'h0, 0, 0, 0, 0, 0};
        vt[19] = '{4'b0000, 4'hF, 4'h0, 0, 0, 4'h0, 0, 0, 0, 0, 0};

        repeat (3) cyc();
        rst = 1'b0;
        chk("reset_status", 32'(st_a), 0);
        chk("reset_cnt", 32'(cnt_a), 0);
        chk("reset_valid", 32'(fv_a), 0);
        chk("reset_fatal", 32'(fat_a), 0);

        // Directed table.
        for (int i = 0; i < 20; i++) begin
            drive(vt[i].f, vt[i].m, vt[i].a, vt[i].cc, vt[i].c);
            cyc();
            chk($sformatf("tbl%0d_status", i), 32'(st_a), 32'(vt[i].st));
            chk($sformatf("tbl%0d_cnt", i), 32'(cnt_a), vt[i].cnt);
            chk($sformatf("tbl%0d_id", i), 32'(fid_a), vt[i].fid);
            chk($sformatf("tbl%0d_valid", i), 32'(fv_a), 32'(vt[i].fv));
            chk($sformatf("tbl%0d_irq", i), 32'(irq_a), 32'(vt[i].irq));
            chk($sformatf("tbl%0d_fatal", i), 32'(fat_a), 32'(vt[i].fat));
        end

        // Escalation: 16 faulty input cycles on channel 3.
        drive(4'b1000, 4'hF, 4'h0, 0, 0);
        repeat (16) cyc();
        fault = 4'h0;
        chk("esc_pre_fatal", 32'(fat_a), 0);
        chk("esc_pre_cnt", 32'(cnt_a), 15);
        cyc();
        chk("esc_fatal", 32'(fat_a), 1);
        chk("esc_cnt", 32'(cnt_a), 16);
        drive(4'h0, 4'hF, 4'hF, 1, 0);
        cyc();
        chk("esc_ack_fatal", 32'(fat_a), 1);
        chk("esc_ack_cnt", 32'(cnt_a), 0);
        chk("esc_ack_status", 32'(st_a), 0);
        drive(4'h0, 4'hF, 4'h0, 0, 1);
        cyc();
        clr = 1'b0;
        chk("esc_clr_fatal", 32'(fat_a), 0);
        chk("esc_clr_valid", 32'(fv_a), 0);
        chk("esc_clr_irq", 32'(irq_a), 0);

        // Saturation on the narrow-counter instance.
        drive(4'b0010, 4'hF, 4'h0, 0, 0);
        repeat (20) cyc();
        fault = 4'h0;
        cyc();
        chk("sat_cnt", 32'(cnt_b), 15);
        chk("sat_fatal", 32'(fat_b), 0);
        fault = 4'b0010;
        cyc();
        cclr = 1'b1;
        cyc();
        chk("sat_clr_cnt", 32'(cnt_b), 0);
        drive(4'h0, 4'hF, 4'h0, 0, 1);
        cyc();
        clr = 1'b0;

        // Masked fault sets status without irq.
        drive(4'b0100, 4'h0, 4'h0, 0, 0);
        cyc();
        fault = 4'h0;
        cyc();
        chk("mask_status", 32'(st_a), 32'(4'b0100));
        chk("mask_irq", 32'(irq_a), 0);

        // Async reset in the middle of a fault train.
        fault = 4'b0011;
        repeat (3) cyc();
        #2 rst = 1'b1;
        #1;
        chk("arst_status", 32'(st_a), 0);
        chk("arst_cnt", 32'(cnt_a), 0);
        chk("arst_irq", 32'(irq_a), 0);
        chk("arst_valid", 32'(fv_a), 0);
        cyc();
        fault = 4'h0;
        rst = 1'b0;
        repeat (2) cyc();
        chk("arst_after_status", 32'(st_a), 0);
        chk("arst_after_cnt", 32'(cnt_a), 0);

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            fault = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
            mask  = 4'($urandom);
            ack   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            cclr  = ($urandom_range(0, 40) == 0);
            clr   = ($urandom_range(0, 80) == 0);
            cyc();
            chk("rnd_status", 32'(st_a), 32'(ma.st));
            chk("rnd_cnt", 32'(cnt_a), ma.cnt);
            chk("rnd_id", 32'(fid_a), ma.fid);
            chk("rnd_valid", 32'(fv_a), 32'(ma.fv));
            chk("rnd_irq", 32'(irq_a), 32'(|(ma.st & mask)));
            chk("rnd_fatal", 32'(fat_a), 32'(ma.mode == 2'd2));
            chk("rnd_b_cnt", 32'(cnt_b), mb.cnt);
            chk("rnd_b_fatal", 32'(fat_b), 32'(mb.mode == 2'd2));
            chk("rnd_b_id", 32'(fid_b), mb.fid);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hwpe_stream_parity_fault_collector.md
# hwpe_stream_parity_fault_collector

Aggregates the `fault_detected_o` outputs of up to NB_CHANNELS parity sinks into a single fault-reporting block. It sits directly downstream of the parity sinks in a protected HWPE streamer, one input per sink. It provides:
- sticky per-channel status with acknowledge;
- a saturating fault-cycle counter;
- first-fault channel capture;
- a maskable interrupt;
- an escalation state machine that raises a fatal flag after too many faulty cycles.

## Interface
- NB_CHANNELS, default 4, number of parity sinks monitored (1..32).
- CNT_WIDTH, default 16, width of the fault-cycle counter.
- FATAL_THRESHOLD, default 16, counter value at which FATAL is entered; 0 disables escalation; must be ≤ 2^CNT_WIDTH−1.
- ID_WIDTH, derived, = max(1, $clog2(NB_CHANNELS)).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- clear_i  in  1  synchronous clear; same effect as reset, highest priority.
- fault_i  in  NB_CHANNELS  one `fault_detected_o` per parity sink.
- mask_i  in  NB_CHANNELS  interrupt enable per channel (1 = enabled).
- ack_i  in  NB_CHANNELS  write-1-to-clear of the sticky status bits.
- cnt_clear_i  in  1  zeroes the fault-cycle counter.
- status_o  out  NB_CHANNELS  sticky per-channel fault flags.
- fault_cnt_o  out  CNT_WIDTH  saturating count of cycles with at least one fault.
- first_id_o  out  ID_WIDTH  lowest-index channel faulting in the first faulty cycle since IDLE.
- first_valid_o  out  1  first_id_o is meaningful.
- irq_o  out  1  = |(status_o & mask_i).
- fatal_o  out  1  high while in FATAL.

## Operation
- **Input stage:** fault_i is registered into fault_q every cycle. fault_i is never used combinationally; this gives a timing cut from the sink comparators.
- **Status bits:** per bit i, next = fault_q[i] | (status[i] & ~ack_i[i]). A fault in the same cycle as ack wins, and the bit stays 1.
- **Counter:**
  - cnt_clear_i=1: next = 0. Clear wins over increment.
  - else if |fault_q: next = cnt + 1, saturating at 2^CNT_WIDTH−1 (no wrap).
  - else: hold.
- **First-fault capture:** when state is IDLE and |fault_q, first_id ← index of the lowest set bit of fault_q, first_valid ← 1. first_id is not updated outside IDLE. first_valid ← 0 on the transition to IDLE.
- **FSM** (state register, reset IDLE). cnt_next is the counter's next value.
  - IDLE → ALARM: |fault_q.
  - IDLE → FATAL: |fault_q and FATAL_THRESHOLD≠0 and cnt_next ≥ FATAL_THRESHOLD. FATAL takes precedence over ALARM.
  - ALARM → IDLE: next status all zero.
  - ALARM → FATAL: FATAL_THRESHOLD≠0 and cnt_next ≥ FATAL_THRESHOLD.
  - FATAL: exits only on clear_i or rst_i. ack_i and cnt_clear_i still act on status and counter but do not leave FATAL.
- **Outputs:** fatal_o = (state==FATAL). irq_o is combinational from registered status_o and mask_i. mask_i does not affect status_o.

## Timing
- **Reset and clear_i:** every output and register is 0 (status_o, fault_cnt_o, first_id_o, first_valid_o, irq_o, fatal_o, fault_q); state is IDLE. Reset is asynchronous on assertion. clear_i takes effect at the next edge and overrides ack_i, cnt_clear_i and fault_q in that cycle.
- **Latency:** fault_i high before edge k:
  - fault_q is set at edge k.
  - status_o, fault_cnt_o, first_id_o, first_valid_o and state update at edge k+1.
  - irq_o and fatal_o are visible after edge k+1.
  - Total: 2 cycles.
- **ack_i:** high before edge k clears the bit at edge k, unless fault_q[i] is 1 at that edge.
- **cnt_clear_i:** high before edge k gives fault_cnt_o = 0 after edge k.
- **Multi-cycle faults:** each faulty cycle increments the counter by 1, regardless of how many channels are set.
- **Same-cycle faults:** faults on several channels in the same cycle set all the corresponding status bits; first_id is the lowest index.
- **Reset mid-fault:** fault_q is discarded; no residual status appears after reset release.

## Test plan
- **Basic fault:** reset; pulse fault_i=4'b0100 for one cycle; mask_i=4'hF.
  - Two edges later: status_o=4'b0100, fault_cnt_o=1, first_id_o=2, first_valid_o=1, irq_o=1.
  - Then ack_i=4'b0100 → status_o=0, irq_o=0, first_valid_o=0, state IDLE; fault_cnt_o stays 1.
- **Simultaneous fault and ack:** status_o=4'b0001; hold fault_i[0] high while pulsing ack_i[0] in the cycle fault_q[0]=1 → status_o[0] stays 1, irq_o stays 1.
- **Multi-channel first-fault:** fault_i=4'b1010 in one cycle, then 4'b0001 → first_id_o=1 (not 0, not 3), status_o=4'b1011, fault_cnt_o=2.
- **Escalation:** FATAL_THRESHOLD=16; hold fault_i[3]=1 for 16 cycles.
  - fatal_o rises 2 cycles after the 16th faulty input cycle.
  - ack_i=4'hF and cnt_clear_i leave fatal_o=1.
  - clear_i → all outputs 0.
- **Saturation:** CNT_WIDTH=4, FATAL_THRESHOLD=0; 20 faulty cycles → fault_cnt_o=15, fatal_o=0. cnt_clear_i coincident with a fault → fault_cnt_o=0.
- **Masking and async reset:** mask_i=4'b0000 with a fault → status_o set, irq_o=0. Assert rst_i mid-fault-train → outputs 0 immediately; after release with fault_i=0, status_o stays 0.
